// File: rtl/output_handler_pkg.sv
// Shared constants and types for the output handler: port map, field widths
// and the per-port channel state encoding.
package output_handler_pkg;

   localparam int PORT_ADDR_W = 3;
   localparam int VALUE_W     = 8;
   localparam int PULSE_LEN_W = 8;

   localparam logic [PORT_ADDR_W-1:0] PORT_LEDS = 3'd0;
   localparam logic [PORT_ADDR_W-1:0] PORT_P6   = 3'd1;
   localparam logic [PORT_ADDR_W-1:0] PORT_P7   = 3'd2;
   localparam logic [PORT_ADDR_W-1:0] PORT_P8   = 3'd3;
   localparam logic [PORT_ADDR_W-1:0] PORT_P9   = 3'd4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_PULSE = 1'b1
   } port_state_t;

endpackage

// File: rtl/output_handler_channel.sv
// One output port: holds its value and, for timed writes, counts pulse ticks
// down and blanks the output when the count expires.
//
// state    | meaning
// ST_IDLE  | output latched at last level value (or 0 after an expired pulse)
// ST_PULSE | output driven, countdown running on shared tick
module out_port_channel
   import output_handler_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tick,
   input  logic                   load,
   input  logic [VALUE_W-1:0]     value,
   input  logic [PULSE_LEN_W-1:0] len,
   output logic [VALUE_W-1:0]     out_val,
   output logic                   active
);

   localparam logic [PULSE_LEN_W-1:0] CNT_ONE = PULSE_LEN_W'(1);

   port_state_t            state_q, state_d;
   logic [PULSE_LEN_W-1:0] cnt_q, cnt_d;
   logic [VALUE_W-1:0]     val_q, val_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
      end
   end

   // A write always wins over a coinciding tick: the fresh length is loaded
   // without being decremented.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      if (load) begin
         val_d = value;
         if (len == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            state_d = ST_PULSE;
            cnt_d   = len;
         end
      end else if (state_q == ST_PULSE && tick) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            val_d   = '0;
         end
      end
   end

   assign out_val = val_q;
   assign active  = (state_q == ST_PULSE);

endmodule

// File: rtl/output_handler.sv
// OUTPUT-instruction sink: decodes writes to five output ports, each able to
// latch a level or emit a timed pulse measured in prescaler ticks.
module output_handler
   import output_handler_pkg::*;
#(
   parameter int TICK_DIV  = 50000,
   parameter int NUM_PORTS = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [PORT_ADDR_W-1:0] wr_port,
   input  logic [15:0]            wr_data,
   output logic                   wr_ack,
   output logic [VALUE_W-1:0]     leds,
   output logic [VALUE_W-1:0]     gpio_p6,
   output logic [VALUE_W-1:0]     gpio_p7,
   output logic [VALUE_W-1:0]     gpio_p8,
   output logic [VALUE_W-1:0]     gpio_p9,
   output logic [NUM_PORTS-1:0]   pulse_active
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc_q;
   logic               tick;
   logic               wr_ack_q;
   logic [VALUE_W-1:0] ch_val [NUM_PORTS];

   // Free-running; the tick is consumed on the edge that wraps back to 0.
   assign tick = (presc_q == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         wr_ack_q <= 1'b0;
      end else begin
         presc_q  <= tick ? '0 : presc_q + PRESC_W'(1);
         wr_ack_q <= wr_en;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
      out_port_channel u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick    (tick),
         .load    (wr_en && (wr_port == PORT_ADDR_W'(i))),
         .value   (wr_data[VALUE_W-1:0]),
         .len     (wr_data[VALUE_W +: PULSE_LEN_W]),
         .out_val (ch_val[i]),
         .active  (pulse_active[i])
      );
   end

   assign wr_ack  = wr_ack_q;
   assign leds    = ch_val[PORT_LEDS];
   assign gpio_p6 = ch_val[PORT_P6];
   assign gpio_p7 = ch_val[PORT_P7];
   assign gpio_p8 = ch_val[PORT_P8];
   assign gpio_p9 = ch_val[PORT_P9];

endmodule

// File: tb/tb_output_handler.sv
// Bench for output_handler: directed writes, a cycle-level reference model
// built from the expiry-time rule, and hand-computed spot checks.
module tb_output_handler;

   localparam int TD = 4;
   localparam int NP = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [2:0]  wr_port;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic [7:0]  leds, gpio_p6, gpio_p7, gpio_p8, gpio_p9;
   logic [4:0]  pulse_active;

   int total = 0;
   int bad   = 0;

   output_handler #(.TICK_DIV(TD), .NUM_PORTS(NP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_port      (wr_port),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .leds         (leds),
      .gpio_p6      (gpio_p6),
      .gpio_p7      (gpio_p7),
      .gpio_p8      (gpio_p8),
      .gpio_p9      (gpio_p9),
      .pulse_active (pulse_active)
   );

   always #5 clk = ~clk;

   // Model: edges are numbered from reset release; ticks land on multiples of
   // TD. A pulse of N written on edge e expires on the N-th tick edge after e.
   int         edge_n;
   logic [7:0] m_val [NP];
   int         m_exp [NP];
   logic       m_ack;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_n = 0;
         m_ack  = 1'b0;
         for (int p = 0; p < NP; p++) begin
            m_val[p] = 8'h00;
            m_exp[p] = 0;
         end
      end else begin
         edge_n = edge_n + 1;
         for (int p = 0; p < NP; p++) begin
            if (m_exp[p] == edge_n) begin
               m_val[p] = 8'h00;
               m_exp[p] = 0;
            end
         end
         m_ack = wr_en;
         if (wr_en && wr_port < 3'd5) begin
            m_val[wr_port] = wr_data[7:0];
            if (wr_data[15:8] == 8'd0) m_exp[wr_port] = 0;
            else m_exp[wr_port] = (edge_n / TD + int'(wr_data[15:8])) * TD;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic [4:0] pa_exp;
         for (int p = 0; p < NP; p++) pa_exp[p] = (m_exp[p] != 0);
         check("model_leds", {24'd0, leds},    {24'd0, m_val[0]});
         check("model_p6",   {24'd0, gpio_p6}, {24'd0, m_val[1]});
         check("model_p7",   {24'd0, gpio_p7}, {24'd0, m_val[2]});
         check("model_p8",   {24'd0, gpio_p8}, {24'd0, m_val[3]});
         check("model_p9",   {24'd0, gpio_p9}, {24'd0, m_val[4]});
         check("model_pact", {27'd0, pulse_active}, {27'd0, pa_exp});
         check("model_ack",  {31'd0, wr_ack},  {31'd0, m_ack});
      end
   end

   function automatic logic [7:0] port_out(input int p);
      case (p)
         0: return leds;
         1: return gpio_p6;
         2: return gpio_p7;
         3: return gpio_p8;
         4: return gpio_p9;
         default: return 8'h00;
      endcase
   endfunction

   // Called on a negedge; the write lands on the following posedge.
   task automatic wr(input logic [2:0] p, input logic [15:0] d);
      wr_en = 1'b1; wr_port = p; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0; wr_port = 3'd0; wr_data = 16'h0000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic measure(input int p, output int dur);
      dur = 0;
      while (port_out(p) != 8'h00 && dur < 40) begin
         dur++;
         @(negedge clk);
      end
   endtask

   int dur;
   int guard;

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_port = 3'd0; wr_data = 16'h0000;
      chk_en = 1'b1;
      idle(3);
      check("rst_leds", {24'd0, leds}, 32'h0);
      check("rst_pact", {27'd0, pulse_active}, 32'h0);
      check("rst_ack",  {31'd0, wr_ack}, 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Level write to leds, held indefinitely.
      wr(3'd0, 16'h00A5);
      check("lvl_leds", {24'd0, leds}, 32'hA5);
      check("lvl_ack",  {31'd0, wr_ack}, 32'h1);
      check("lvl_pact0", {31'd0, pulse_active[0]}, 32'h0);
      idle(1);
      check("lvl_ack_drop", {31'd0, wr_ack}, 32'h0);
      idle(1000);
      check("lvl_hold", {24'd0, leds}, 32'hA5);

      // Pulse of 3 ticks on gpio_p7.
      wr(3'd2, 16'h033C);
      check("p7_val",  {24'd0, gpio_p7}, 32'h3C);
      check("p7_pact", {31'd0, pulse_active[2]}, 32'h1);
      measure(2, dur);
      check("p7_dur_9to12", {31'd0, (dur >= 9 && dur <= 12)}, 32'h1);
      check("p7_pact_end", {31'd0, pulse_active[2]}, 32'h0);

      // Restart a running pulse on gpio_p6 one cycle after its first tick.
      wr(3'd1, 16'h0322);
      guard = 0;
      @(negedge clk);
      while (edge_n % TD != 0 && guard < 2 * TD) begin
         @(negedge clk);
         guard++;
      end
      wr(3'd1, 16'h0511);
      check("p6_restart_val", {24'd0, gpio_p6}, 32'h11);
      measure(1, dur);
      check("p6_restart_dur", dur, 32'd19);

      // Cancel a pulse with a level write, then an ignored write to port 6.
      wr(3'd4, 16'h0A44);
      idle(5);
      wr(3'd4, 16'h0077);
      idle(100);
      check("p9_cancel", {24'd0, gpio_p9}, 32'h77);
      check("p9_pact",   {31'd0, pulse_active[4]}, 32'h0);
      wr(3'd6, 16'h0355);
      check("inv_ack",  {31'd0, wr_ack}, 32'h1);
      check("inv_leds", {24'd0, leds},    32'hA5);
      check("inv_p6",   {24'd0, gpio_p6}, 32'h00);
      check("inv_p7",   {24'd0, gpio_p7}, 32'h00);
      check("inv_p8",   {24'd0, gpio_p8}, 32'h00);
      check("inv_p9",   {24'd0, gpio_p9}, 32'h77);
      check("inv_pact", {27'd0, pulse_active}, 32'h0);

      // Write landing exactly on a tick edge: no decrement, full 2*TD cycles.
      guard = 0;
      while ((edge_n + 1) % TD != 0 && guard < 2 * TD) begin
         @(negedge clk);
         guard++;
      end
      wr(3'd3, 16'h0299);
      check("coin_val", {24'd0, gpio_p8}, 32'h99);
      measure(3, dur);
      check("coin_dur", dur, 32'd8);

      // Back-to-back writes to different ports.
      wr(3'd0, 16'h0081);
      wr(3'd2, 16'h0142);
      check("b2b_leds", {24'd0, leds},    32'h81);
      check("b2b_p7",   {24'd0, gpio_p7}, 32'h42);
      check("b2b_ack",  {31'd0, wr_ack},  32'h1);

      // Asynchronous reset in the middle of a pulse on gpio_p8.
      wr(3'd3, 16'h0A12);
      idle(3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_p8",   {24'd0, gpio_p8}, 32'h0);
      check("arst_pact", {27'd0, pulse_active}, 32'h0);
      check("arst_leds", {24'd0, leds}, 32'h0);
      check("arst_ack",  {31'd0, wr_ack}, 32'h0);
      idle(2);
      rst_n = 1'b1;
      idle(60);
      check("post_p8",   {24'd0, gpio_p8}, 32'h0);
      check("post_pact", {27'd0, pulse_active}, 32'h0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
